divide_sequencer: RTL and testbench

//  Sequencer for the clock divider: plays a programmed list of (divide, dwell)

---
 rtl/divide_sequencer.sv | 179 +++++++++++++++++
 tb/tb_divide_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divide_sequencer.sv
// Plays a table of (divide, dwell) entries onto the clock divider's divide input.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | divide held at IDLE_DIV; table writable; a valid start arms the
//        | entry-0 snapshot (pend_q) and RUN begins on the following edge
//  RUN   | current entry on divide; dwell counter counts down to 1, then the
//        | next entry is loaded (or wrap / finish / stop)
module divide_sequencer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned DWELL_W  = 32,
    parameter logic [31:0] IDLE_DIV = 32'd0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [31:0]                wr_divide,
    input  logic [DWELL_W-1:0]         wr_dwell,
    input  logic [$clog2(DEPTH):0]     seq_len,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       stop,
    output logic [31:0]                divide,
    output logic                       busy,
    output logic [$clog2(DEPTH)-1:0]   step_idx,
    output logic                       done,
    output logic                       err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic               pend_q, pend_d;
    logic [AW:0]        len_q, len_d;
    logic               loop_q, loop_d;
    logic [31:0]        pdiv_q, pdiv_d;
    logic [DWELL_W-1:0] pdw_q, pdw_d;
    logic [31:0]        div_q, div_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [31:0]        tbl_div [DEPTH];
    logic [DWELL_W-1:0] tbl_dw  [DEPTH];

    logic [AW-1:0]      idx_inc;
    logic               is_last;
    logic               len_ok;

    // A dwell of zero still shows the entry for one cycle.
    function automatic logic [DWELL_W-1:0] dwell_min1(input logic [DWELL_W-1:0] d);
        return (d == '0) ? DWELL_W'(1) : d;
    endfunction

    assign idx_inc = idx_q + AW'(1);
    assign is_last = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));
    assign len_ok  = (seq_len != '0) && (seq_len <= DEPTH_L);

    // Table storage: writes only land while idle; no reset on the array.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == S_IDLE)) begin
            tbl_div[wr_addr] <= wr_divide;
            tbl_dw[wr_addr]  <= wr_dwell;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            pdiv_q  <= '0;
            pdw_q   <= '0;
            div_q   <= IDLE_DIV;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            pdiv_q  <= pdiv_d;
            pdw_q   <= pdw_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-datapath decisions.
    always_comb begin
        state_d = state_q;
        pend_d  = 1'b0;
        len_d   = len_q;
        loop_d  = loop_q;
        pdiv_d  = pdiv_q;
        pdw_d   = pdw_q;
        div_d   = div_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                div_d = IDLE_DIV;
                idx_d = '0;
                cnt_d = '0;
                if (pend_q) begin
                    // Snapshot taken at the start edge, so a same-cycle write
                    // to entry 0 does not affect this run.
                    if (!stop) begin
                        state_d = S_RUN;
                        div_d   = pdiv_q;
                        cnt_d   = pdw_q;
                    end
                end else if (start && !stop) begin
                    if (len_ok) begin
                        pend_d = 1'b1;
                        len_d  = seq_len;
                        loop_d = loop;
                        pdiv_d = tbl_div[0];
                        pdw_d  = dwell_min1(tbl_dw[0]);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                err_d = wr_en;
                if (stop) begin
                    state_d = S_IDLE;
                    div_d   = IDLE_DIV;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == DWELL_W'(1)) begin
                    if (!is_last) begin
                        idx_d = idx_inc;
                        div_d = tbl_div[idx_inc];
                        cnt_d = dwell_min1(tbl_dw[idx_inc]);
                    end else if (loop_q) begin
                        idx_d = '0;
                        div_d = tbl_div[0];
                        cnt_d = dwell_min1(tbl_dw[0]);
                    end else begin
                        state_d = S_IDLE;
                        div_d   = IDLE_DIV;
                        idx_d   = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: all come straight from flops so the divider sees clean steps.
    always_comb begin
        busy     = (state_q == S_RUN);
        divide   = div_q;
        step_idx = idx_q;
        done     = done_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_divide_sequencer.sv
// Bench for divide_sequencer: stimulus pushes expected output cycles into a
// queue, a negedge monitor pops and compares whenever the DUT shows activity.
module tb_divide_sequencer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_divide = '0;
    logic [31:0] wr_dwell = '0;
    logic [3:0]  seq_len = '0;
    logic        loop = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] divide;
    logic        busy;
    logic [2:0]  step_idx;
    logic        done;
    logic        err;

    divide_sequencer #(.DEPTH(DEPTH), .DWELL_W(32), .IDLE_DIV(32'd0)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_divide(wr_divide), .wr_dwell(wr_dwell), .seq_len(seq_len),
        .loop(loop), .start(start), .stop(stop), .divide(divide), .busy(busy),
        .step_idx(step_idx), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int dv;
        int idx;
        int bsy;
        int dn;
        int er;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc_cnt = 0;
    bit   mon_en = 1'b0;
    int   m_div[DEPTH];
    int   m_dw[DEPTH];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Simple divider the sequencer feeds: toggles every 'divide' clk cycles.
    logic        new_clk;
    int          dcnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dcnt    <= 0;
            new_clk <= 1'b0;
        end else if (divide == 0) begin
            dcnt <= 0;
        end else if (dcnt >= int'(divide) - 1) begin
            dcnt    <= 0;
            new_clk <= ~new_clk;
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    // Monitor: any cycle with busy/done/err is an output event.
    always @(negedge clk) begin
        if (mon_en && reset_n && (busy || done || err)) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_output cyc=%0d divide=%0d idx=%0d busy=%0b done=%0b err=%0b, expected no output",
                         cyc_cnt, divide, step_idx, busy, done, err);
            end else begin
                mon_e = sb.pop_front();
                if (int'(divide) == mon_e.dv && int'(step_idx) == mon_e.idx &&
                    int'(busy) == mon_e.bsy && int'(done) == mon_e.dn &&
                    int'(err) == mon_e.er && cyc_cnt == mon_e.cyc)
                    n_pass++;
                else
                    $display("FAIL output got cyc=%0d div=%0d idx=%0d busy=%0b done=%0b err=%0b expected cyc=%0d div=%0d idx=%0d busy=%0d done=%0d err=%0d",
                             cyc_cnt, divide, step_idx, busy, done, err,
                             mon_e.cyc, mon_e.dv, mon_e.idx, mon_e.bsy, mon_e.dn, mon_e.er);
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d expected=%0d", nm, got, want);
    endtask

    task automatic cyc_t();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rec(input int dv, input int idx, input int bsy, input int dn,
                            input int er, input int cyc);
        exp_t r;
        r.dv = dv; r.idx = idx; r.bsy = bsy; r.dn = dn; r.er = er; r.cyc = cyc;
        sb.push_back(r);
    endtask

    // Expected playback from the bench's own table copy.
    task automatic push_run(input int t0, input int len, input bit lp, input int nmax,
                            input int err_at);
        int c = t0 + 1;
        int i = 0;
        int n = 0;
        int dw;
        while (n < nmax) begin
            dw = (m_dw[i] == 0) ? 1 : m_dw[i];
            for (int j = 0; j < dw && n < nmax; j++) begin
                push_rec(m_div[i], i, 1, 0, (c == err_at) ? 1 : 0, c);
                c++;
                n++;
            end
            if (n >= nmax) break;
            i++;
            if (i == len) begin
                if (lp) i = 0;
                else begin
                    push_rec(0, 0, 0, 1, 0, c);
                    break;
                end
            end
        end
    endtask

    task automatic wr(input int a, input int dv, input int dw, input bit upd);
        wr_en = 1'b1;
        wr_addr = a[2:0];
        wr_divide = dv;
        wr_dwell = dw;
        cyc_t();
        wr_en = 1'b0;
        if (upd) begin
            m_div[a] = dv;
            m_dw[a] = dw;
        end
    endtask

    task automatic start_run(input int len, input bit lp, output int t0);
        seq_len = len[3:0];
        loop = lp;
        start = 1'b1;
        cyc_t();
        t0 = cyc_cnt;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || sb.size() != 0) && k < budget) begin
            cyc_t();
            k++;
        end
        n_chk++;
        if (k < budget) n_pass++;
        else $display("FAIL wait_idle timeout busy=%0b pending=%0d expected 0/0", busy, sb.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired, expected bench to finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int last;
        int ntog;
        int changes;
        logic prev;

        repeat (3) cyc_t();
        chk("reset_divide", int'(divide), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_idx", int'(step_idx), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        reset_n = 1'b1;
        mon_en = 1'b1;
        cyc_t();

        // Basic play
        wr(0, 10, 3, 1);
        wr(1, 20, 2, 1);
        wr(2, 30, 1, 1);
        start_run(3, 0, t0);
        push_run(t0, 3, 0, 1000, -1);
        wait_idle(50);

        // Loop, stopped on the second pass at entry 20
        start_run(3, 1, t0);
        push_run(t0, 3, 1, 10, -1);
        repeat (10) cyc_t();
        stop = 1'b1;
        cyc_t();
        stop = 1'b0;
        wait_idle(20);
        cyc_t();
        chk("stop_busy", int'(busy), 0);

        // Full table including zero dwells; entry 3 is (5,0)
        for (int i = 0; i < DEPTH; i++) wr(i, (i == 3) ? 5 : 100 + i, i % 3, 1);
        start_run(DEPTH, 0, t0);
        push_run(t0, DEPTH, 0, 1000, -1);
        wait_idle(100);

        // Length bounds
        start_run(0, 0, t0);
        push_rec(0, 0, 0, 0, 1, t0);
        repeat (2) cyc_t();
        chk("len0_busy", int'(busy), 0);
        start_run(DEPTH + 1, 0, t0);
        push_rec(0, 0, 0, 0, 1, t0);
        repeat (2) cyc_t();
        chk("len9_busy", int'(busy), 0);
        wait_idle(10);

        // Write during RUN rejected, start during RUN ignored
        start_run(DEPTH, 0, t0);
        push_run(t0, DEPTH, 0, 1000, t0 + 3);
        repeat (2) cyc_t();
        wr(2, 999, 7, 0);
        cyc_t();
        start = 1'b1;
        cyc_t();
        start = 1'b0;
        wait_idle(100);
        start_run(DEPTH, 0, t0);
        push_run(t0, DEPTH, 0, 1000, -1);
        wait_idle(100);

        // start+stop together in IDLE does nothing
        seq_len = 4'd3;
        start = 1'b1;
        stop = 1'b1;
        repeat (2) cyc_t();
        start = 1'b0;
        stop = 1'b0;
        repeat (3) cyc_t();
        chk("startstop_busy", int'(busy), 0);

        // Write and start in the same cycle: old entry 0 plays
        wr_en = 1'b1;
        wr_addr = 3'd0;
        wr_divide = 77;
        wr_dwell = 2;
        start_run(1, 0, t0);
        wr_en = 1'b0;
        push_run(t0, 1, 0, 1000, -1);
        m_div[0] = 77;
        m_dw[0] = 2;
        wait_idle(20);
        start_run(1, 0, t0);
        push_run(t0, 1, 0, 1000, -1);
        wait_idle(20);

        // Divider integration
        wr(0, 10, 40, 1);
        start_run(1, 0, t0);
        push_run(t0, 1, 0, 1000, -1);
        repeat (5) cyc_t();
        prev = new_clk;
        last = -1;
        ntog = 0;
        for (int k = 0; k < 30; k++) begin
            cyc_t();
            if (new_clk !== prev) begin
                if (last >= 0) chk("div_period", k - last, 10);
                last = k;
                ntog++;
            end
            prev = new_clk;
        end
        chk("div_toggles", (ntog >= 2) ? 1 : 0, 1);
        wait_idle(50);
        prev = new_clk;
        changes = 0;
        for (int k = 0; k < 20; k++) begin
            cyc_t();
            if (new_clk !== prev) changes++;
            prev = new_clk;
        end
        chk("div_flat_idle", changes, 0);

        // Async reset in the middle of a looping run
        start_run(1, 1, t0);
        push_run(t0, 1, 1, 4, -1);
        repeat (4) cyc_t();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_divide", int'(divide), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_idx", int'(step_idx), 0);
        sb.delete();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc_t();
            chk("post_rst_divide", int'(divide), 0);
            chk("post_rst_busy", int'(busy), 0);
        end
        mon_en = 1'b1;
        repeat (3) cyc_t();

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
